// File: rtl/vga_sync_checker_if.sv
// rtl/vga_sync_checker_if.sv - VGA video bus between a generator and the sync checker
interface vga_sync_checker_if;
   logic       pix_en;
   logic [2:0] red;
   logic [2:0] green;
   logic [1:0] blue;
   logic       hsync;
   logic       vsync;

   modport master (output pix_en, red, green, blue, hsync, vsync);
   modport slave  (input  pix_en, red, green, blue, hsync, vsync);
endinterface

// File: rtl/vga_sync_checker.sv
// rtl/vga_sync_checker.sv - passive VGA timing monitor with lock, sticky errors and frame checksum
module vga_sync_checker #(
   parameter int H_TOTAL = 800,
   parameter int H_PULSE = 96,
   parameter int H_BP    = 144,
   parameter int H_FP    = 784,
   parameter int V_TOTAL = 521,
   parameter int V_PULSE = 2,
   parameter int V_BP    = 31,
   parameter int V_FP    = 511
) (
   input  logic               clk,
   input  logic               clr,
   vga_sync_checker_if.slave  vga,
   output logic               locked,
   output logic               h_err,
   output logic               v_err,
   output logic [15:0]        frame_sum,
   output logic               frame_valid,
   output logic [15:0]        frame_cnt
);
   localparam logic [10:0] PX_MAX   = 11'h7ff;
   localparam logic [9:0]  LN_MAX   = 10'h3ff;
   localparam logic [10:0] PX_PULSE = 11'(H_PULSE);
   localparam logic [10:0] PX_TOTAL = 11'(H_TOTAL);
   localparam logic [10:0] PX_BP    = 11'(H_BP);
   localparam logic [10:0] PX_FP    = 11'(H_FP);
   localparam logic [9:0]  LN_PULSE = 10'(V_PULSE);
   localparam logic [9:0]  LN_TOTAL = 10'(V_TOTAL);
   localparam logic [9:0]  LN_BP    = 10'(V_BP);
   localparam logic [9:0]  LN_FP    = 10'(V_FP);

   typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [7:0]  pix_cur;
   logic        hs_cur, vs_cur, hs_prev, vs_prev;
   logic [10:0] px, px_inc, px_now;
   logic [9:0]  ln, ln_inc, ln_now;
   logic        h_ref, v_ref, dirty;
   logic [15:0] acc;
   logic        h_fall, h_rise, v_fall, v_rise;
   logic        h_viol, v_viol, frame_bad, frame_ok, active;

   // edge detection and the position/violation view of the sample held in the first register
   always_comb begin
      h_fall    = hs_prev & ~hs_cur;
      h_rise    = ~hs_prev & hs_cur;
      v_fall    = vs_prev & ~vs_cur;
      v_rise    = ~vs_prev & vs_cur;
      px_inc    = (px == PX_MAX) ? px : px + 11'd1;
      px_now    = h_fall ? 11'd0 : px_inc;
      ln_inc    = (ln == LN_MAX) ? ln : ln + 10'd1;
      ln_now    = h_fall ? (v_fall ? 10'd0 : ln_inc) : ln;
      h_viol    = h_ref & ((h_rise & (px_inc != PX_PULSE)) | (h_fall & (px_inc != PX_TOTAL)));
      v_viol    = v_ref & ((v_rise & ~(h_fall & (ln_now == LN_PULSE))) |
                           (v_fall & ~(h_fall & (ln_inc == LN_TOTAL))));
      frame_bad = dirty | h_viol | v_viol;
      active    = (px_now >= PX_BP) && (px_now < PX_FP) && (ln_now >= LN_BP) && (ln_now < LN_FP);
   end

   // capture the bus on each pixel tick; the previous sync sample is kept for edge detection
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pix_cur <= 8'h00;
         hs_cur  <= 1'b0;
         vs_cur  <= 1'b0;
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
      end else if (vga.pix_en) begin
         pix_cur <= {vga.red, vga.green, vga.blue};
         hs_cur  <= vga.hsync;
         vs_cur  <= vga.vsync;
         hs_prev <= hs_cur;
         vs_prev <= vs_cur;
      end
   end

   // pixel and line indices plus the reference edges that arm the checks
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         px    <= 11'd0;
         ln    <= 10'd0;
         h_ref <= 1'b0;
         v_ref <= 1'b0;
      end else if (vga.pix_en) begin
         px <= px_now;
         ln <= ln_now;
         if (h_fall) h_ref <= 1'b1;
         if (v_fall) v_ref <= 1'b1;
      end
   end

   // active-area checksum and the per-frame error marker, both restarted at each vsync fall
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         acc   <= 16'h0000;
         dirty <= 1'b0;
      end else if (vga.pix_en) begin
         if (v_fall)      acc <= 16'h0000;
         else if (active) acc <= acc + {8'h00, pix_cur};
         dirty <= v_fall ? 1'b0 : (dirty | h_viol | v_viol);
      end
   end

   // sticky error flags, cleared only by reset
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         h_err <= 1'b0;
         v_err <= 1'b0;
      end else if (vga.pix_en) begin
         if (h_viol) h_err <= 1'b1;
         if (v_viol) v_err <= 1'b1;
      end
   end

   // lock state register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= SEARCH;
      else      state <= state_nxt;
   end

   // frame boundaries drive the lock sequence; a violation while locked drops it at once
   always_comb begin
      state_nxt = state;
      if (vga.pix_en) begin
         case (state)
            SEARCH:  if (v_fall) state_nxt = ALIGN;
            ALIGN:   if (v_fall && !frame_bad) state_nxt = LOCKED;
            LOCKED:  if (h_viol || v_viol) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
         endcase
      end
   end

   // lock indication and clean-frame completion strobe
   always_comb begin
      locked   = (state == LOCKED);
      frame_ok = vga.pix_en & v_fall & (state != SEARCH) & ~frame_bad;
   end

   // publish a clean frame's checksum; frame_valid is a single clk regardless of pix_en
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         frame_sum   <= 16'h0000;
         frame_valid <= 1'b0;
         frame_cnt   <= 16'h0000;
      end else begin
         frame_valid <= frame_ok;
         if (frame_ok) begin
            frame_sum <= acc;
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_vga_sync_checker.sv
// tb/tb_vga_sync_checker.sv - randomized self-checking bench for vga_sync_checker
module tb_vga_sync_checker;
   localparam int HT = 40, HP = 6, HBP = 10, HFP = 34;
   localparam int VT = 21, VP = 2, VBP = 4, VFP = 20;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        locked, h_err, v_err, frame_valid;
   logic [15:0] frame_sum, frame_cnt;

   vga_sync_checker_if vif();

   vga_sync_checker #(
      .H_TOTAL(HT), .H_PULSE(HP), .H_BP(HBP), .H_FP(HFP),
      .V_TOTAL(VT), .V_PULSE(VP), .V_BP(VBP), .V_FP(VFP)
   ) dut (
      .clk(clk), .clr(clr), .vga(vif),
      .locked(locked), .h_err(h_err), .v_err(v_err),
      .frame_sum(frame_sum), .frame_valid(frame_valid), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // expected outputs as visible at the pins
   bit          exp_locked, exp_h, exp_v, exp_valid;
   logic [15:0] exp_sum, exp_cnt;

   // model state after the most recent sample
   int          m_n, m_hf_idx, m_line, m_phase;
   bit          m_ph, m_pv, m_href, m_vref, m_dirty, m_herr, m_verr, m_pulse;
   logic [15:0] m_acc, m_sum, m_cnt;

   // generator state
   int g_px, g_ln, g_frame, g_vfalls;
   int cfg_pattern, cfg_gate;
   int cfg_short_frame = -1;
   int cfg_vlow_frame  = -1;
   bit g_prev_v;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("locked",      16'(locked),      16'(exp_locked));
         check("h_err",       16'(h_err),       16'(exp_h));
         check("v_err",       16'(v_err),       16'(exp_v));
         check("frame_valid", 16'(frame_valid), 16'(exp_valid));
         check("frame_sum",   frame_sum,        exp_sum);
         check("frame_cnt",   frame_cnt,        exp_cnt);
      end
   end

   task automatic model_reset();
      m_n = 0; m_hf_idx = 0; m_line = 0; m_phase = 0;
      m_ph = 0; m_pv = 0; m_href = 0; m_vref = 0; m_dirty = 0;
      m_herr = 0; m_verr = 0; m_pulse = 0;
      m_acc = 16'h0; m_sum = 16'h0; m_cnt = 16'h0;
      exp_locked = 0; exp_h = 0; exp_v = 0; exp_valid = 0;
      exp_sum = 16'h0; exp_cnt = 16'h0;
   endtask

   // one accepted sample: results become visible one pixel tick later
   task automatic model_tick(input bit h, input bit v, input logic [7:0] p);
      bit hf, hr, vf, vr, he, ve, err, clean, act;
      int px, ln;
      exp_locked = (m_phase == 2);
      exp_h      = m_herr;
      exp_v      = m_verr;
      exp_sum    = m_sum;
      exp_cnt    = m_cnt;
      exp_valid  = m_pulse;
      m_pulse    = 0;
      m_n++;
      hf = m_ph && !h;
      hr = !m_ph && h;
      vf = m_pv && !v;
      vr = !m_pv && v;
      px = hf ? 0 : (m_n - m_hf_idx);
      ln = hf ? (vf ? 0 : ((m_line + 1 > 1023) ? 1023 : m_line + 1)) : m_line;
      he = m_href && ((hr && px != HP) || (hf && (m_n - m_hf_idx) != HT));
      ve = m_vref && ((vr && !(hf && ln == VP)) || (vf && !(hf && m_line + 1 == VT)));
      act = (px >= HBP) && (px < HFP) && (ln >= VBP) && (ln < VFP);
      err = he || ve;
      if (he) m_herr = 1;
      if (ve) m_verr = 1;
      if (vf) begin
         clean = !m_dirty && !err;
         if (m_phase != 0 && clean) begin
            m_sum = m_acc;
            m_cnt = m_cnt + 16'd1;
            m_pulse = 1;
         end
         if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1 && clean) m_phase = 2;
         else if (m_phase == 2 && !clean) m_phase = 0;
         m_dirty = 0;
         m_acc = 16'h0;
      end else begin
         if (act) m_acc = m_acc + 16'(p);
         if (err) begin
            m_dirty = 1;
            if (m_phase == 2) m_phase = 0;
         end
      end
      if (hf) begin
         m_hf_idx = m_n;
         m_href = 1;
         m_line = ln;
      end
      if (vf) m_vref = 1;
      m_ph = h;
      m_pv = v;
   endtask

   task automatic drive(input bit en, input bit h, input bit v, input logic [7:0] p);
      @(negedge clk);
      vif.pix_en = en;
      vif.hsync  = h;
      vif.vsync  = v;
      {vif.red, vif.green, vif.blue} = p;
      if (en) model_tick(h, v, p);
      else    exp_valid = 0;
   endtask

   task automatic emit_pixel();
      int idle, len, vlow;
      bit h, v;
      logic [7:0] p;
      idle = (cfg_gate == 1) ? 1 : (cfg_gate == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int i = 0; i < idle; i++) drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
      vlow = (g_frame == cfg_vlow_frame) ? VP + 1 : VP;
      h = (g_px >= HP);
      v = (g_ln >= vlow);
      if (cfg_pattern == 0) p = 8'hFF;
      else if (cfg_pattern == 1 && g_px >= HBP && g_px < HFP && g_ln >= VBP && g_ln < VFP)
         p = 8'(g_px - HBP);
      else p = 8'($urandom);
      drive(1'b1, h, v, p);
      if (g_prev_v && !v) g_vfalls++;
      g_prev_v = v;
      len = (g_frame == cfg_short_frame && g_ln == 5) ? HT - 1 : HT;
      g_px++;
      if (g_px >= len) begin
         g_px = 0;
         g_ln++;
         if (g_ln >= VT) begin
            g_ln = 0;
            g_frame++;
         end
      end
   endtask

   task automatic run_falls(input int k);
      int target;
      target = g_vfalls + k;
      for (int i = 0; i < k * HT * VT + 2 * HT && g_vfalls < target; i++) emit_pixel();
      emit_pixel();
      emit_pixel();
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      clr = 1'b0;
      vif.pix_en = 1'b0;
      #1;
      check({tag, "_rst_locked"},  16'(locked),      16'h0);
      check({tag, "_rst_h_err"},   16'(h_err),       16'h0);
      check({tag, "_rst_v_err"},   16'(v_err),       16'h0);
      check({tag, "_rst_valid"},   16'(frame_valid), 16'h0);
      check({tag, "_rst_sum"},     frame_sum,        16'h0);
      check({tag, "_rst_cnt"},     frame_cnt,        16'h0);
      model_reset();
      g_prev_v = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      clr = 1'b1;
   endtask

   initial begin
      vif.pix_en = 1'b0; vif.hsync = 1'b1; vif.vsync = 1'b1;
      vif.red = 3'd0; vif.green = 3'd0; vif.blue = 2'd0;
      model_reset();
      do_reset("init");

      // nominal constant-white stream starting mid-frame
      g_ln = int'($urandom_range(5, VT - 1));
      g_px = int'($urandom_range(0, HT - 1));
      g_frame = 0; g_vfalls = 0;
      cfg_pattern = 0; cfg_gate = 0;
      run_falls(4);
      check("nom_cnt",    frame_cnt,     16'd3);
      check("nom_locked", 16'(locked),   16'h1);
      check("nom_sum",    frame_sum,     16'h7E80);
      check("nom_h_err",  16'(h_err),    16'h0);
      check("nom_v_err",  16'(v_err),    16'h0);

      // ramp pattern in the active area
      cfg_pattern = 1;
      run_falls(2);
      check("ramp_sum", frame_sum, 16'h1140);
      check("ramp_cnt", frame_cnt, 16'd5);

      // one short line
      cfg_pattern = 2;
      cfg_short_frame = g_frame;
      run_falls(1);
      check("short_h_err",  16'(h_err),  16'h1);
      check("short_locked", 16'(locked), 16'h0);
      check("short_cnt",    frame_cnt,   16'd5);
      run_falls(1);
      check("short_relock", 16'(locked), 16'h1);
      check("short_cnt2",   frame_cnt,   16'd6);
      check("short_sticky", 16'(h_err),  16'h1);

      // vsync held low one line too long
      cfg_vlow_frame = g_frame;
      run_falls(1);
      check("vlong_v_err",  16'(v_err),  16'h1);
      check("vlong_locked", 16'(locked), 16'h0);
      check("vlong_cnt",    frame_cnt,   16'd6);
      run_falls(1);
      check("vlong_relock", 16'(locked), 16'h1);
      check("vlong_cnt2",   frame_cnt,   16'd7);

      // reset in the middle of a frame
      repeat (7 * HT) emit_pixel();
      do_reset("mid");
      run_falls(1);
      check("mid_locked", 16'(locked), 16'h0);
      check("mid_h_err",  16'(h_err),  16'h0);
      check("mid_v_err",  16'(v_err),  16'h0);
      run_falls(1);
      check("mid_relock", 16'(locked), 16'h1);
      check("mid_cnt",    frame_cnt,   16'd1);

      // pixel enable on every other clk
      cfg_gate = 1;
      cfg_pattern = 1;
      run_falls(2);
      check("gate_sum", frame_sum, 16'h1140);
      check("gate_cnt", frame_cnt, 16'd3);

      // irregular enable with random pixels
      cfg_gate = 2;
      cfg_pattern = 2;
      run_falls(3);
      check("rand_cnt",    frame_cnt,   16'd6);
      check("rand_locked", 16'(locked), 16'h1);
      check("rand_h_err",  16'(h_err),  16'h0);
      check("rand_v_err",  16'(v_err),  16'h0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_sync_checker.md
# vga_sync_checker

Passive VGA monitor that sits on the far end of the display interface driven by the demo top level (`red`, `green`, `blue`, `hsync`, `vsync`). It samples the video bus on a pixel-rate enable, measures hsync/vsync periods and pulse widths against the 640x480 timing parameters, and reports lock and sticky error flags. It also produces a per-frame checksum of active-area pixels. It is used in simulation benches and on-board as a self-check of the VGA generator.

## Interface
- `H_TOTAL`, 800, pixels per line
- `H_PULSE`, 96, hsync low width in pixels
- `H_BP`, 144, first active pixel index (pixel 0 = hsync falling edge)
- `H_FP`, 784, first pixel after active area
- `V_TOTAL`, 521, lines per frame
- `V_PULSE`, 2, vsync low width in lines
- `V_BP`, 31, first active line index (line 0 = vsync falling edge)
- `V_FP`, 511, first line after active area
- `clk`  in  1  system clock; one clock domain, all logic on rising edge
- `clr`  in  1  reset, asynchronous, active-low
- `pix_en`  in  1  pixel-rate enable, one clk cycle per pixel
- `red`  in  3  pixel red
- `green`  in  3  pixel green
- `blue`  in  2  pixel blue
- `hsync`  in  1  horizontal sync, active-low
- `vsync`  in  1  vertical sync, active-low
- `locked`  out  1  timing verified for at least one full clean frame
- `h_err`  out  1  sticky horizontal timing error
- `v_err`  out  1  sticky vertical timing error
- `frame_sum`  out  16  checksum of last completed frame
- `frame_valid`  out  1  one-clk pulse when `frame_sum` updates from a clean frame
- `frame_cnt`  out  16  count of `frame_valid` pulses, wraps at 65535->0

## Operation
- Pixel byte = {red, green, blue}. All inputs are registered on `pix_en`. A second register on `pix_en` holds the previous sample, and edges are detected between the two.
- Pixel index `px` (11 bits): 0 on the tick where an hsync falling edge is detected, otherwise +1 per `pix_en`, saturating at 2047.
- Line index `ln` (10 bits): updated only at hsync falling edges. Set to 0 if vsync fell on that edge, otherwise +1, saturating at 1023.
- Horizontal checks, applied once a previous hsync fall has been seen:
  - hsync rising edge must occur at `px` == H_PULSE.
  - the next falling edge must occur at `px` == H_TOTAL.
  - any violation sets `h_err`.
- Vertical checks, applied once a previous vsync fall has been seen:
  - vsync rise must coincide with an hsync fall at `ln` == V_PULSE.
  - the next vsync fall must occur at `ln` == V_TOTAL.
  - a vsync edge not coincident with an hsync falling edge is an error.
  - any violation sets `v_err`.
- Checksum: a 16-bit accumulator adds the pixel byte (zero-extended, modulo 2^16) when H_BP <= `px` < H_FP and V_BP <= `ln` < V_FP. It clears at every vsync fall after its value has been transferred.
- State machine, 3 states; all transitions are evaluated at vsync falling edges except forced ones:
  - SEARCH: waiting for a frame boundary. Goes to ALIGN on a vsync fall; the frame error flag is cleared.
  - ALIGN: observing the first full frame. At the next vsync fall, goes to LOCKED if no error occurred during the frame, otherwise stays in ALIGN.
  - LOCKED: any h or v violation forces an immediate return to SEARCH and deasserts `locked`.
- Frame completion: on a vsync fall in ALIGN or LOCKED with a clean frame, load `frame_sum`, pulse `frame_valid`, and increment `frame_cnt`. A frame containing an error updates nothing.
- `h_err` and `v_err` are sticky and clear only on `clr`.

## Timing
- Reset (`clr` low, asynchronous): state SEARCH; all outputs 0, meaning `locked`=0, `h_err`=0, `v_err`=0, `frame_sum`=16'h0000, `frame_valid`=0, `frame_cnt`=0; counters and sample registers 0.
- Reset release: the first hsync/vsync falls only establish reference. No error can be flagged before a reference edge exists, so reset mid-frame never produces a false error.
- Latency: error flags, `locked`, and `frame_valid` assert 2 `pix_en` ticks after the offending or terminating input value is present at the pins.
- `frame_valid` is exactly one clk wide even if `pix_en` is held high.
- `pix_en` low: no sampling, no counting, outputs hold. `frame_valid` still drops after 1 clk.
- Simultaneous events: a horizontal error and a vsync fall on the same tick means the frame is dirty, with no `frame_valid`, and the state returns to SEARCH.
- With nominal timing, `locked` rises at the second vsync fall after reset.

## Test plan
- Nominal generator (800x521, pixel byte 8'hFF constant), 3 frames plus the 4th vsync fall -> `locked`=1 after the 2nd fall; `frame_sum`=16'h5000 each frame; `frame_cnt`=3; `h_err`=`v_err`=0.
- Pattern pixel = (px-144)[7:0] in active area -> `frame_sum`=16'hA800 per frame.
- One line of 799 pixels in frame 2 -> `h_err`=1 and `locked`=0 two ticks after the early hsync fall; no `frame_valid` for that frame; `locked` returns 2 vsync falls later; `h_err` stays 1.
- vsync low for 3 lines -> `v_err`=1, `locked`=0; `frame_cnt` frozen for the dirty frame.
- `clr` pulsed low mid-frame 2 -> all outputs 0 within the same cycle; no error flagged after release; `locked` after the 2nd subsequent vsync fall.
- `pix_en` gated 1-of-2 cycles versus continuous -> identical `frame_sum` and `frame_cnt`; `frame_valid` exactly 1 clk wide.
